// File: rtl/bky_rdbk_fsm_pkg.sv
// bky_rdbk_fsm_pkg: shared state encoding and default geometry for the readback FSM
package bky_rdbk_fsm_pkg;
  localparam int WBITS_DEF  = 16;
  localparam int NWORDS_DEF = 18;
  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    SHIFT     = 3'b001,
    WAIT4ROOM = 3'b010,
    WRITE     = 3'b011,
    SET_DONE  = 3'b100
  } state_e;
endpackage

// File: rtl/bky_rdbk_fsm_if.sv
// bky_rdbk_fsm_if: request, chain and FIFO-side signals of the readback FSM
interface bky_rdbk_fsm_if #(parameter int WBITS = 16);
  logic             START;
  logic             FULL;
  logic             SDIN;
  logic             SHFT_ENA;
  logic             WRENA;
  logic [WBITS-1:0] DOUT;
  logic             DONE;
  modport master (output START, FULL, SDIN, input SHFT_ENA, WRENA, DOUT, DONE);
  modport slave  (input START, FULL, SDIN, output SHFT_ENA, WRENA, DOUT, DONE);
endinterface

// File: rtl/bky_rdbk_deser.sv
// bky_rdbk_deser: MSB-first serial-to-parallel word assembly with output word register
module bky_rdbk_deser #(
  parameter int WBITS = 16,
  parameter int BW    = $clog2(WBITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             load,
  input  logic             sdin,
  output logic [BW-1:0]    bcnt_o,
  output logic [WBITS-1:0] dout_o
);
  logic [WBITS-1:0] sreg_q, sreg_d, dout_q, dout_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  // the final bit is folded into the loaded word on the same edge it is captured
  always_comb begin
    sreg_d = shift ? {sreg_q[WBITS-2:0], sdin} : sreg_q;
    bcnt_d = clr ? '0 : shift ? ((bcnt_q == BW'(WBITS-1)) ? '0 : bcnt_q + 1'b1) : bcnt_q;
    dout_d = load ? sreg_d : dout_q;
  end
  // falling-edge storage with asynchronous clear
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      bcnt_q <= '0;
      dout_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      bcnt_q <= bcnt_d;
      dout_q <= dout_d;
    end
  end
  assign bcnt_o = bcnt_q;
  assign dout_o = dout_q;
endmodule

// File: rtl/bky_rdbk.sv
// bky_rdbk_fsm: reads a scan chain word by word into a FIFO, stalling on FULL
module bky_rdbk_fsm
  import bky_rdbk_fsm_pkg::*;
#(
  parameter int WBITS  = WBITS_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input logic          CLK,
  input logic          RST,
  bky_rdbk_fsm_if.slave bus
);
  localparam int BW = $clog2(WBITS);
  localparam int WW = $clog2(NWORDS + 1);
  state_e          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [BW-1:0]   bcnt;
  logic [WBITS-1:0] dout;
  logic            shft_ena_q, wrena_q, done_q;
  logic            last_bit;
  assign last_bit = bcnt == BW'(WBITS-1);
  // next-state and word counter; FULL only matters on the last bit and while waiting
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d = SHIFT;
          wcnt_d  = '0;
        end
      end
      SHIFT:     if (last_bit) state_d = bus.FULL ? WAIT4ROOM : WRITE;
      WAIT4ROOM: if (!bus.FULL) state_d = WRITE;
      WRITE: begin
        wcnt_d  = wcnt_q + 1'b1;
        state_d = (wcnt_q == WW'(NWORDS-1)) ? SET_DONE : SHIFT;
      end
      SET_DONE:  if (!bus.START) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // state, counter and outputs registered from the next state
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      shft_ena_q <= 1'b0;
      wrena_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      shft_ena_q <= state_d == SHIFT;
      wrena_q    <= state_d == WRITE;
      done_q     <= state_d == SET_DONE;
    end
  end
  bky_rdbk_deser #(.WBITS(WBITS), .BW(BW)) u_deser (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (state_q == IDLE && bus.START),
    .shift (state_q == SHIFT),
    .load  (state_d == WRITE),
    .sdin  (bus.SDIN),
    .bcnt_o(bcnt),
    .dout_o(dout)
  );
  assign bus.SHFT_ENA = shft_ena_q;
  assign bus.WRENA    = wrena_q;
  assign bus.DONE     = done_q;
  assign bus.DOUT     = dout;
endmodule

// File: tb/tb_bky_rdbk_fsm.sv
// tb_bky_rdbk_fsm: directed checks of the chain readback FSM against a chain model
module tb_bky_rdbk_fsm;
  logic CLK, RST;
  int checks, failures, ptr;
  logic [15:0] w [18];
  bky_rdbk_fsm_if #(.WBITS(16)) bus ();
  bky_rdbk_fsm dut (.CLK(CLK), .RST(RST), .bus(bus));
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int dly_word, input int dly_len, input int ign_edge,
                     input bit pulse, input int stop_at);
    int nwr, nsh, done_e, we, ws;
    bit stopped;
    nwr = 0; nsh = 0; done_e = -1; ptr = 0; stopped = 0;
    ws = 17 * dly_word + 16;
    @(posedge CLK);
    bus.START = 1'b1;
    bus.FULL  = 1'b0;
    for (int c = 0; c < 400 && done_e < 0 && !stopped; c++) begin
      @(posedge CLK);
      if (pulse && c == 0) bus.START = 1'b0;
      if (bus.SHFT_ENA) nsh++;
      if (bus.WRENA) begin
        if (nwr < 18) begin
          we = 17 * nwr + 16 + ((dly_word >= 0 && nwr >= dly_word) ? dly_len : 0);
          chk("wr_edge", c, we);
          chk("dout", int'(bus.DOUT), int'(w[nwr]));
        end
        nwr++;
      end
      if (dly_word >= 0 && c >= ws && c < ws + dly_len) begin
        chk("stall_shft", int'(bus.SHFT_ENA), 0);
        chk("stall_wr", int'(bus.WRENA), 0);
      end
      if (bus.DONE) done_e = c;
      if (c == stop_at) stopped = 1;
      bus.FULL = (dly_word >= 0 && c + 1 >= ws && c + 1 < ws + dly_len) || (c + 1 == ign_edge);
      if (bus.SHFT_ENA && ptr < 288) begin
        bus.SDIN = w[ptr / 16][15 - ptr % 16];
        ptr++;
      end
    end
    if (!stopped) begin
      chk("done_edge", done_e, 306 + dly_len);
      chk("n_writes", nwr, 18);
      chk("n_shifts", nsh, 288);
    end
  endtask
  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 18; i++) w[i] = 16'hA5C3 ^ 16'(i * 16'h1357);
    bus.START = 1'b0; bus.FULL = 1'b0; bus.SDIN = 1'b0;
    RST = 1'b1;
    #2 RST = 1'b0;
    #1;
    chk("rst_shft", int'(bus.SHFT_ENA), 0);
    chk("rst_wr", int'(bus.WRENA), 0);
    chk("rst_done", int'(bus.DONE), 0);
    chk("rst_dout", int'(bus.DOUT), 0);
    repeat (2) @(posedge CLK);
    RST = 1'b1;
    run(-1, 0, -1, 0, -1);
    repeat (3) begin
      @(posedge CLK);
      chk("done_hold", int'(bus.DONE), 1);
    end
    bus.START = 1'b0;
    @(posedge CLK);
    chk("done_drop", int'(bus.DONE), 0);
    chk("idle_shft", int'(bus.SHFT_ENA), 0);
    run(3, 10, 112, 1, -1);
    @(posedge CLK);
    chk("pulse_done_clr", int'(bus.DONE), 0);
    run(-1, 0, -1, 0, 160);
    bus.START = 1'b0;
    chk("pre_rst_shft", int'(bus.SHFT_ENA), 1);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_shft", int'(bus.SHFT_ENA), 0);
    chk("mid_rst_wr", int'(bus.WRENA), 0);
    chk("mid_rst_done", int'(bus.DONE), 0);
    chk("mid_rst_dout", int'(bus.DOUT), 0);
    repeat (3) @(posedge CLK);
    RST = 1'b1;
    repeat (5) begin
      @(posedge CLK);
      chk("post_rst_idle", int'({bus.SHFT_ENA, bus.WRENA, bus.DONE}), 0);
    end
    run(-1, 0, -1, 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
